// File: rtl/tc_stack_pkg.sv
// ---------------------------------------------------------------------------
// tc_stack_pkg
// Shared types and constants for the TC RAM stack engine.
//   state_t      : controller FSM states (IDLE, WRITE, READ, CAPTURE)
//   DEF_*        : default widths / geometry for the stack
//   LATENCY_POP  : cycles from an accepted pop (or peek) to pop_valid
// ---------------------------------------------------------------------------
package tc_stack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_BASE   = 0;
  localparam int DEF_DEPTH  = 256;

  localparam int LATENCY_POP = 3;

endpackage

// File: rtl/tc_stack_ptr.sv
// ---------------------------------------------------------------------------
// tc_stack_ptr
// Stack pointer for the TC RAM stack: holds the entry count, steps it up on
// an accepted push and down on an accepted pop, and derives full/empty plus
// the two RAM addresses the controller needs.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   inc        : accepted push this cycle
//   dec        : accepted pop this cycle (never together with inc)
//   count      : current number of entries (0..DEPTH)
//   full       : count == DEPTH
//   empty      : count == 0
//   push_addr  : BASE + count      (next free slot)
//   top_addr   : BASE + count - 1  (top of stack)
// Address arithmetic wraps modulo 2^ADDR_W.
// ---------------------------------------------------------------------------
module tc_stack_ptr #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top_addr
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + (ADDR_W + 1)'(1);
    end else if (dec) begin
      count <= count - (ADDR_W + 1)'(1);
    end
  end

  always_comb begin
    full      = (count == DEPTH_C);
    empty     = (count == '0);
    // Only the low ADDR_W bits matter: count == 2^ADDR_W can only occur when
    // the stack is full, and then push_addr is never used.
    push_addr = BASE_C + count[ADDR_W-1:0];
    top_addr  = push_addr - ADDR_W'(1);
  end

endmodule

// File: rtl/tc_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tc_stack_ctrl
// LIFO stack engine in front of the 8-bit TC RAM. Turns push/pop requests
// (accepted while ready is high) into RAM cycles with the RAM's timing:
// reads are sampled by the RAM at posedge with data on ram_out one cycle
// later, writes commit at the negedge of the cycle ram_save is high.
//
// Optional build macro: TC_STACK_PEEK_EN
//   When defined, adds input 'peek': reads the top of stack without popping.
//   Priority push > pop > peek.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   push         : push request, word on push_data
//   pop          : pop request
//   peek         : (TC_STACK_PEEK_EN only) read top without removing it
//   ready        : controller idle; a request presented now is acted on
//   pop_valid    : one-cycle pulse, pop_data holds the popped/peeked word
//   pop_data     : last popped word, held until the next pop_valid
//   full, empty  : count == DEPTH / count == 0
//   count        : current number of entries
//   err          : one-cycle pulse after a rejected request
//   ram_load     : RAM read enable (registered)
//   ram_save     : RAM write enable (registered)
//   ram_address  : RAM address (registered)
//   ram_in       : RAM write data (registered)
//   ram_out      : RAM read data (0 when not loading)
//
// Pop timing: accept in cycle N, ram_load high in N+1, data on ram_out in
// N+2, pop_valid in N+3. Push: accept in N, ram_save high in N+1, next
// accept possible in N+2.
// ---------------------------------------------------------------------------
module tc_stack_ctrl
  import tc_stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BASE   = DEF_BASE,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
`ifdef TC_STACK_PEEK_EN
  input  logic              peek,
`endif
  output logic              ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              ram_load,
  output logic              ram_save,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  // The stack must fit in the RAM without wrapping onto itself.
  if (BASE + DEPTH > (1 << ADDR_W)) begin : g_bad_geometry
    $error("tc_stack_ctrl: BASE + DEPTH exceeds the RAM address space");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("tc_stack_ctrl: DEPTH must be at least 1");
  end

  state_t              state;
  logic                idle;
  logic                peek_req;
  logic                do_push;
  logic                do_pop;
  logic                do_peek;
  logic                reject;
  logic [ADDR_W-1:0]   push_addr;
  logic [ADDR_W-1:0]   top_addr;

`ifdef TC_STACK_PEEK_EN
  assign peek_req = peek;
`else
  assign peek_req = 1'b0;
`endif

  tc_stack_ptr #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE),
    .DEPTH  (DEPTH)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .inc       (do_push),
    .dec       (do_pop),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .push_addr (push_addr),
    .top_addr  (top_addr)
  );

  assign ready = (state == IDLE);

  // Request arbitration: only evaluated while idle; anything presented while
  // busy is dropped silently. Push always wins; a pop alongside a push is an
  // error even when the push itself goes through.
  always_comb begin
    idle    = (state == IDLE);
    do_push = idle & push & ~full;
    do_pop  = idle & ~push & pop & ~empty;
    do_peek = idle & ~push & ~pop & peek_req & ~empty;
    reject  = idle & ((push & (full | pop)) |
                      (~push & pop & empty) |
                      (~push & ~pop & peek_req & empty));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ram_load    <= 1'b0;
      ram_save    <= 1'b0;
      ram_address <= BASE_A;
      ram_in      <= '0;
      pop_valid   <= 1'b0;
      pop_data    <= '0;
      err         <= 1'b0;
    end else begin
      // Strobes default low; each is raised for exactly one cycle below.
      ram_load  <= 1'b0;
      ram_save  <= 1'b0;
      pop_valid <= 1'b0;
      err       <= reject;
      case (state)
        IDLE: begin
          if (do_push) begin
            ram_save    <= 1'b1;
            ram_address <= push_addr;
            ram_in      <= push_data;
            state       <= WRITE;
          end else if (do_pop || do_peek) begin
            ram_load    <= 1'b1;
            ram_address <= top_addr;
            state       <= READ;
          end
        end
        // RAM commits the word at the negedge of this cycle.
        WRITE: begin
          state <= IDLE;
        end
        // RAM samples the read at the posedge closing this cycle.
        READ: begin
          state <= CAPTURE;
        end
        // Read data is on ram_out now; register it for the consumer.
        CAPTURE: begin
          pop_data  <= ram_out;
          pop_valid <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
